// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-master (instruction/data) arbiter onto one shared memory port
//
// Purpose: grants either the instruction (prefetch) bus or the data
// (load/store) bus to the single shared memory port. A grant is held until
// the slave acks or the granted master withdraws, and every grant ends with
// one IDLE cycle in which the next owner is chosen. Data wins by default;
// with FAIR=1 a pending instruction request wins when data won the previous
// completed transfer.
//
// Ports:
//   clk, reset           core clock, synchronous active-high reset
//   instr_m_*            instruction master: addr, access in; data_in, ack out
//   data_m_*             data master: addr, data_out, access, wr_en, bytesel in;
//                        data_in, ack out
//   q_m_*                shared port: addr, data_out, access, wr_en, bytesel out;
//                        data_in, ack in
//   q_b                  current owner (0 = instruction, 1 = data)

module mem_arbiter #(
  parameter bit FAIR = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [18:0] instr_m_addr,
  input  logic        instr_m_access,
  output logic [15:0] instr_m_data_in,
  output logic        instr_m_ack,
  input  logic [18:0] data_m_addr,
  input  logic [15:0] data_m_data_out,
  input  logic        data_m_access,
  input  logic        data_m_wr_en,
  input  logic [1:0]  data_m_bytesel,
  output logic [15:0] data_m_data_in,
  output logic        data_m_ack,
  output logic [18:0] q_m_addr,
  output logic [15:0] q_m_data_out,
  output logic        q_m_access,
  output logic        q_m_wr_en,
  output logic [1:0]  q_m_bytesel,
  input  logic [15:0] q_m_data_in,
  input  logic        q_m_ack,
  output logic        q_b
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } state_t;

  state_t r_state;
  logic   r_last_d;   // 1 = data master completed the most recent transfer

  // Grants are masked by reset so that a reset cycle drops the shared
  // request immediately and swallows any in-flight ack.
  logic w_gnt_i;
  logic w_gnt_d;
  assign w_gnt_i = (r_state == GRANT_I) && !reset;
  assign w_gnt_d = (r_state == GRANT_D) && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_last_d <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          // An ack seen here belongs to nobody and is ignored.
          if (instr_m_access && (!data_m_access || (FAIR && r_last_d)))
            r_state <= GRANT_I;
          else if (data_m_access)
            r_state <= GRANT_D;
          else
            r_state <= IDLE;
        end
        GRANT_I: begin
          if (q_m_ack) begin
            r_last_d <= 1'b0;
            r_state  <= IDLE;
          end else if (!instr_m_access) begin
            r_state  <= IDLE;
          end
        end
        GRANT_D: begin
          if (q_m_ack) begin
            r_last_d <= 1'b1;
            r_state  <= IDLE;
          end else if (!data_m_access) begin
            r_state  <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Shared port passthrough; everything is zero when nobody is granted.
  assign q_m_access   = (w_gnt_i && instr_m_access) || (w_gnt_d && data_m_access);
  assign q_m_addr     = w_gnt_i ? instr_m_addr : (w_gnt_d ? data_m_addr : 19'h0);
  assign q_m_data_out = w_gnt_d ? data_m_data_out : 16'h0;
  assign q_m_wr_en    = w_gnt_d && data_m_wr_en;
  assign q_m_bytesel  = w_gnt_i ? 2'b11 : (w_gnt_d ? data_m_bytesel : 2'b00);
  assign q_b          = w_gnt_d;

  // Return path to the owner only.
  assign instr_m_ack     = w_gnt_i && q_m_ack;
  assign data_m_ack      = w_gnt_d && q_m_ack;
  assign instr_m_data_in = w_gnt_i ? q_m_data_in : 16'h0;
  assign data_m_data_in  = w_gnt_d ? q_m_data_in : 16'h0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter

module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [18:0] instr_m_addr;
  logic        instr_m_access;
  logic [18:0] data_m_addr;
  logic [15:0] data_m_data_out;
  logic        data_m_access;
  logic        data_m_wr_en;
  logic [1:0]  data_m_bytesel;
  logic [15:0] q_m_data_in;
  logic        q_m_ack;

  // FAIR=1 instance
  logic [15:0] instr_m_data_in, data_m_data_in, q_m_data_out;
  logic        instr_m_ack, data_m_ack, q_m_access, q_m_wr_en, q_b;
  logic [18:0] q_m_addr;
  logic [1:0]  q_m_bytesel;

  // FAIR=0 instance
  logic [15:0] f0_instr_m_data_in, f0_data_m_data_in, f0_q_m_data_out;
  logic        f0_instr_m_ack, f0_data_m_ack, f0_q_m_access, f0_q_m_wr_en, f0_q_b;
  logic [18:0] f0_q_m_addr;
  logic [1:0]  f0_q_m_bytesel;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.FAIR(1'b1)) dut (
    .clk(clk), .reset(reset),
    .instr_m_addr(instr_m_addr), .instr_m_access(instr_m_access),
    .instr_m_data_in(instr_m_data_in), .instr_m_ack(instr_m_ack),
    .data_m_addr(data_m_addr), .data_m_data_out(data_m_data_out),
    .data_m_access(data_m_access), .data_m_wr_en(data_m_wr_en),
    .data_m_bytesel(data_m_bytesel), .data_m_data_in(data_m_data_in),
    .data_m_ack(data_m_ack),
    .q_m_addr(q_m_addr), .q_m_data_out(q_m_data_out), .q_m_access(q_m_access),
    .q_m_wr_en(q_m_wr_en), .q_m_bytesel(q_m_bytesel),
    .q_m_data_in(q_m_data_in), .q_m_ack(q_m_ack), .q_b(q_b)
  );

  mem_arbiter #(.FAIR(1'b0)) dut0 (
    .clk(clk), .reset(reset),
    .instr_m_addr(instr_m_addr), .instr_m_access(instr_m_access),
    .instr_m_data_in(f0_instr_m_data_in), .instr_m_ack(f0_instr_m_ack),
    .data_m_addr(data_m_addr), .data_m_data_out(data_m_data_out),
    .data_m_access(data_m_access), .data_m_wr_en(data_m_wr_en),
    .data_m_bytesel(data_m_bytesel), .data_m_data_in(f0_data_m_data_in),
    .data_m_ack(f0_data_m_ack),
    .q_m_addr(f0_q_m_addr), .q_m_data_out(f0_q_m_data_out), .q_m_access(f0_q_m_access),
    .q_m_wr_en(f0_q_m_wr_en), .q_m_bytesel(f0_q_m_bytesel),
    .q_m_data_in(q_m_data_in), .q_m_ack(q_m_ack), .q_b(f0_q_b)
  );

  // Packed view of the FAIR=1 outputs:
  // {q_access, q_addr, q_wr, q_bsel, q_dout, q_b, i_ack, d_ack, i_din, d_din}
  logic [73:0] w_out;
  assign w_out = {q_m_access, q_m_addr, q_m_wr_en, q_m_bytesel, q_m_data_out,
                  q_b, instr_m_ack, data_m_ack, instr_m_data_in, data_m_data_in};

  function automatic logic [73:0] eo(
    input logic qa, input logic [18:0] qaddr, input logic qwr, input logic [1:0] qbs,
    input logic [15:0] qdo, input logic qb, input logic iack, input logic dack,
    input logic [15:0] idin, input logic [15:0] ddin);
    return {qa, qaddr, qwr, qbs, qdo, qb, iack, dack, idin, ddin};
  endfunction

  typedef struct {
    logic        rst;
    logic        i_acc;
    logic [18:0] i_addr;
    logic        d_acc;
    logic [18:0] d_addr;
    logic [15:0] d_dout;
    logic        d_wr;
    logic [1:0]  d_bsel;
    logic [15:0] q_din;
    logic        q_ack;
    logic [73:0] exp;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  task automatic drive(input logic rst, input logic i_acc, input logic [18:0] i_addr,
                       input logic d_acc, input logic [18:0] d_addr, input logic [15:0] d_dout,
                       input logic d_wr, input logic [1:0] d_bsel,
                       input logic [15:0] q_din, input logic q_ack);
    reset           = rst;
    instr_m_access  = i_acc;
    instr_m_addr    = i_addr;
    data_m_access   = d_acc;
    data_m_addr     = d_addr;
    data_m_data_out = d_dout;
    data_m_wr_en    = d_wr;
    data_m_bytesel  = d_bsel;
    q_m_data_in     = q_din;
    q_m_ack         = q_ack;
  endtask

  task automatic check(input string name, input logic [73:0] act, input logic [73:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    logic [73:0] z;
    z = '0;

    // rst,i_acc,i_addr,d_acc,d_addr,d_dout,d_wr,d_bsel,q_din,q_ack,expected
    vecs[0]  = '{1'b1, 1'b0, 19'h0,     1'b0, 19'h0,     16'h0,    1'b0, 2'b00, 16'h0,    1'b0, z};
    vecs[1]  = '{1'b0, 1'b0, 19'h0,     1'b0, 19'h0,     16'h0,    1'b0, 2'b00, 16'h1111, 1'b1, z};
    vecs[2]  = '{1'b0, 1'b1, 19'h00100, 1'b0, 19'h0,     16'h0,    1'b0, 2'b00, 16'h1111, 1'b0, z};
    vecs[3]  = '{1'b0, 1'b1, 19'h00100, 1'b0, 19'h0,     16'h0,    1'b0, 2'b00, 16'hBEEF, 1'b0,
                 eo(1'b1, 19'h00100, 1'b0, 2'b11, 16'h0, 1'b0, 1'b0, 1'b0, 16'hBEEF, 16'h0)};
    vecs[4]  = '{1'b0, 1'b1, 19'h00100, 1'b0, 19'h0,     16'h0,    1'b0, 2'b00, 16'hBEEF, 1'b1,
                 eo(1'b1, 19'h00100, 1'b0, 2'b11, 16'h0, 1'b0, 1'b1, 1'b0, 16'hBEEF, 16'h0)};
    vecs[5]  = '{1'b0, 1'b0, 19'h0,     1'b1, 19'h12345, 16'hA55A, 1'b1, 2'b01, 16'h1234, 1'b0, z};
    vecs[6]  = '{1'b0, 1'b1, 19'h00200, 1'b1, 19'h12345, 16'hA55A, 1'b1, 2'b01, 16'h1234, 1'b1,
                 eo(1'b1, 19'h12345, 1'b1, 2'b01, 16'hA55A, 1'b1, 1'b0, 1'b1, 16'h0, 16'h1234)};
    vecs[7]  = '{1'b0, 1'b1, 19'h00200, 1'b0, 19'h0,     16'h0,    1'b0, 2'b00, 16'h0,    1'b0, z};
    vecs[8]  = '{1'b0, 1'b0, 19'h00200, 1'b1, 19'h00042, 16'h0,    1'b0, 2'b11, 16'h5555, 1'b0,
                 eo(1'b0, 19'h00200, 1'b0, 2'b11, 16'h0, 1'b0, 1'b0, 1'b0, 16'h5555, 16'h0)};
    vecs[9]  = '{1'b0, 1'b0, 19'h0,     1'b1, 19'h00042, 16'h0,    1'b0, 2'b11, 16'h0,    1'b0, z};
    vecs[10] = '{1'b0, 1'b0, 19'h0,     1'b1, 19'h00042, 16'h0,    1'b0, 2'b11, 16'h7777, 1'b0,
                 eo(1'b1, 19'h00042, 1'b0, 2'b11, 16'h0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h7777)};
    vecs[11] = '{1'b1, 1'b0, 19'h0,     1'b1, 19'h00042, 16'h0,    1'b0, 2'b11, 16'h7777, 1'b1, z};
    vecs[12] = '{1'b0, 1'b1, 19'h00200, 1'b1, 19'h00042, 16'h0,    1'b0, 2'b11, 16'h0,    1'b0, z};
    vecs[13] = '{1'b0, 1'b1, 19'h00200, 1'b1, 19'h00042, 16'h0,    1'b0, 2'b11, 16'h2222, 1'b1,
                 eo(1'b1, 19'h00042, 1'b0, 2'b11, 16'h0, 1'b1, 1'b0, 1'b1, 16'h0, 16'h2222)};
    vecs[14] = '{1'b0, 1'b1, 19'h00200, 1'b1, 19'h00042, 16'h0,    1'b0, 2'b11, 16'h0,    1'b0, z};
    vecs[15] = '{1'b0, 1'b1, 19'h00200, 1'b1, 19'h00042, 16'h0,    1'b0, 2'b11, 16'h3333, 1'b1,
                 eo(1'b1, 19'h00200, 1'b0, 2'b11, 16'h0, 1'b0, 1'b1, 1'b0, 16'h3333, 16'h0)};
    vecs[16] = '{1'b0, 1'b0, 19'h0,     1'b0, 19'h0,     16'h0,    1'b0, 2'b00, 16'h0,    1'b0, z};

    drive(1'b1, 1'b0, 19'h0, 1'b0, 19'h0, 16'h0, 1'b0, 2'b00, 16'h0, 1'b0);

    // Table: one vector per cycle, inputs set after negedge, sampled before posedge.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].i_acc, vecs[i].i_addr, vecs[i].d_acc, vecs[i].d_addr,
            vecs[i].d_dout, vecs[i].d_wr, vecs[i].d_bsel, vecs[i].q_din, vecs[i].q_ack);
      #1;
      check($sformatf("vec%0d", i), w_out, vecs[i].exp);
    end

    // Both masters requesting forever, slave acks every cycle (ignored in IDLE).
    // FAIR=1 must alternate D,I,D,I; FAIR=0 must serve data only.
    @(negedge clk);
    drive(1'b1, 1'b1, 19'h00300, 1'b1, 19'h00400, 16'h0, 1'b0, 2'b11, 16'h0, 1'b1);
    for (int k = 0; k < 12; k++) begin
      logic [1:0] e1, e0;
      @(negedge clk);
      reset = 1'b0;
      #1;
      e1 = (k % 4 == 1) ? 2'b01 : ((k % 4 == 3) ? 2'b10 : 2'b00);
      e0 = (k % 2 == 1) ? 2'b01 : 2'b00;
      check($sformatf("fair1_cyc%0d_iack_dack", k), {62'h0, instr_m_ack, data_m_ack}, {62'h0, e1});
      check($sformatf("fair0_cyc%0d_iack_dack", k), {62'h0, f0_instr_m_ack, f0_data_m_ack}, {62'h0, e0});
    end

    // Data withdraws in its first grant cycle while instruction waits; the
    // next arbitration must still see last_served = instruction (data wins).
    @(negedge clk);
    drive(1'b1, 1'b0, 19'h00300, 1'b0, 19'h00400, 16'h0, 1'b0, 2'b11, 16'h0, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b0, 19'h00300, 1'b1, 19'h00400, 16'h0, 1'b0, 2'b11, 16'h0, 1'b0);
    #1;
    check("wd_idle", {72'h0, q_m_access, q_b}, 74'h0);
    @(negedge clk);
    drive(1'b0, 1'b1, 19'h00300, 1'b0, 19'h00400, 16'h0, 1'b0, 2'b11, 16'h0, 1'b0);
    #1;
    check("wd_grant_d_dropped", {71'h0, q_m_access, q_b, data_m_ack}, {71'h0, 3'b010});
    @(negedge clk);
    drive(1'b0, 1'b1, 19'h00300, 1'b1, 19'h00400, 16'h0, 1'b0, 2'b11, 16'h0, 1'b0);
    #1;
    check("wd_back_to_idle", {72'h0, q_m_access, q_b}, 74'h0);
    @(negedge clk);
    q_m_ack = 1'b1;
    #1;
    check("wd_regrant_d", {71'h0, q_m_access, q_b, data_m_ack}, {71'h0, 3'b111});
    @(negedge clk);
    q_m_ack = 1'b0;
    #1;
    check("wd_idle2", {72'h0, q_m_access, q_b}, 74'h0);
    @(negedge clk);
    #1;
    check("wd_then_instr", {45'h0, q_m_access, q_b, q_m_addr, q_m_bytesel, q_m_wr_en},
          {45'h0, 1'b1, 1'b0, 19'h00300, 2'b11, 1'b0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
